id_ex_pipe: RTL and testbench



---
 rtl/id_ex_pipe_pkg.sv | 43 ++++
 rtl/id_ex_bypass.sv | 30 +++
 rtl/id_ex_pipe.sv | 128 ++++++++++++
 tb/tb_id_ex_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_pipe_pkg
// Purpose : Shared definitions for the ID/EX stage: data widths, control
//           bundle bit positions, bubble constant and the stage record.
// Rev     : 1.0  initial release
// ============================================================================
package id_ex_pipe_pkg;

   localparam int XLEN  = 32;
   localparam int REGW  = 5;
   localparam int CTRLW = 16;

   // Control bundle bit positions (shared with decode and EX).
   localparam int CTRL_MEM_READ  = 0;
   localparam int CTRL_MEM_WRITE = 1;
   localparam int CTRL_REG_WRITE = 2;
   localparam int CTRL_ALU_SRC   = 3;
   localparam int CTRL_WB_SEL_LO = 4;   // WB_SEL[1:0]  -> bits 5:4
   localparam int CTRL_ALU_OP_LO = 6;   // ALU_OP[4:0]  -> bits 10:6
   localparam int CTRL_FUNCT3_LO = 11;  // FUNCT3[2:0]  -> bits 13:11

   localparam logic [CTRLW-1:0] CTRL_NOP   = 16'h0000;
   localparam logic [15:0]      BUBBLE_MAX = 16'hFFFF;

   // One ID/EX pipeline slot.
   typedef struct packed {
      logic             valid;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  data1;
      logic [XLEN-1:0]  data2;
      logic [XLEN-1:0]  imm;
      logic [REGW-1:0]  rs1;
      logic [REGW-1:0]  rs2;
      logic [REGW-1:0]  rd;
      logic [CTRLW-1:0] ctrl;
   } id_ex_t;

   // A bubble is an all-zero slot (valid=0, ctrl=NOP, rd=x0).
   localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_bypass.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_bypass
// Purpose : Operand select for one register-file read port. Forces x0 to
//           zero and forwards same-cycle writeback data over stale reads.
// Rev     : 1.0  initial release
// ============================================================================
module id_ex_bypass
   import id_ex_pipe_pkg::*;
(
   input  logic [REGW-1:0] rs_i,
   input  logic [XLEN-1:0] data_i,
   input  logic            wb_write_i,
   input  logic [REGW-1:0] wb_addr_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic [XLEN-1:0] operand_o
);

   // x0 wins over everything, then the in-flight writeback, then the read.
   always_comb begin
      operand_o = data_i;
      if (rs_i == '0) begin
         operand_o = '0;
      end else if (wb_write_i && (wb_addr_i == rs_i)) begin
         operand_o = wb_data_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_pipe
// Purpose : ID/EX pipeline register with writeback bypass on capture,
//           held-operand refresh during stalls, load-use bubble insertion
//           and a saturating bubble counter.
// Rev     : 1.0  initial release
// ============================================================================
module id_ex_pipe
   import id_ex_pipe_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              valid_i,
   input  logic [XLEN-1:0]   pc_i,
   input  logic [XLEN-1:0]   data1_i,
   input  logic [XLEN-1:0]   data2_i,
   input  logic [XLEN-1:0]   imm_i,
   input  logic [REGW-1:0]   rs1_i,
   input  logic [REGW-1:0]   rs2_i,
   input  logic [REGW-1:0]   rd_i,
   input  logic              use_rs1_i,
   input  logic              use_rs2_i,
   input  logic [CTRLW-1:0]  ctrl_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              wb_write_i,
   input  logic [REGW-1:0]   wb_addr_i,
   input  logic [XLEN-1:0]   wb_data_i,
   output logic              valid_o,
   output logic [XLEN-1:0]   pc_o,
   output logic [XLEN-1:0]   data1_o,
   output logic [XLEN-1:0]   data2_o,
   output logic [XLEN-1:0]   imm_o,
   output logic [REGW-1:0]   rs1_o,
   output logic [REGW-1:0]   rs2_o,
   output logic [REGW-1:0]   rd_o,
   output logic [CTRLW-1:0]  ctrl_o,
   output logic              stall_req_o,
   output logic [15:0]       bubble_count_o
);

   id_ex_t      stage_q, stage_d;
   logic [15:0] bubble_cnt_q, bubble_cnt_d;
   logic [XLEN-1:0] op1_sel, op2_sel;
   logic        hz;

   id_ex_bypass u_bypass_rs1 (
      .rs_i       (rs1_i),
      .data_i     (data1_i),
      .wb_write_i (wb_write_i),
      .wb_addr_i  (wb_addr_i),
      .wb_data_i  (wb_data_i),
      .operand_o  (op1_sel)
   );

   id_ex_bypass u_bypass_rs2 (
      .rs_i       (rs2_i),
      .data_i     (data2_i),
      .wb_write_i (wb_write_i),
      .wb_addr_i  (wb_addr_i),
      .wb_data_i  (wb_data_i),
      .operand_o  (op2_sel)
   );

   // Load in EX whose destination is read by the instruction now in decode.
   always_comb begin
      hz = stage_q.valid && stage_q.ctrl[CTRL_MEM_READ] && (stage_q.rd != '0) && valid_i &&
           ((use_rs1_i && (rs1_i == stage_q.rd)) || (use_rs2_i && (rs2_i == stage_q.rd)));
      stall_req_o = hz && !stall_i && !flush_i;
   end

   // Next-state: flush > stall (hold + refresh) > load-use bubble > capture.
   always_comb begin
      stage_d      = stage_q;
      bubble_cnt_d = bubble_cnt_q;
      if (flush_i) begin
         stage_d = ID_EX_BUBBLE;
      end else if (stall_i) begin
         // An older instruction may retire while this one is parked here.
         if (wb_write_i && (wb_addr_i == stage_q.rs1) && (stage_q.rs1 != '0)) begin
            stage_d.data1 = wb_data_i;
         end
         if (wb_write_i && (wb_addr_i == stage_q.rs2) && (stage_q.rs2 != '0)) begin
            stage_d.data2 = wb_data_i;
         end
      end else if (hz) begin
         stage_d = ID_EX_BUBBLE;
         if (bubble_cnt_q != BUBBLE_MAX) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
         end
      end else begin
         stage_d.valid = valid_i;
         stage_d.pc    = pc_i;
         stage_d.data1 = op1_sel;
         stage_d.data2 = op2_sel;
         stage_d.imm   = imm_i;
         stage_d.rs1   = rs1_i;
         stage_d.rs2   = rs2_i;
         stage_d.rd    = rd_i;
         stage_d.ctrl  = valid_i ? ctrl_i : CTRL_NOP;
      end
   end

   // Pipeline slot and counter registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_q      <= ID_EX_BUBBLE;
         bubble_cnt_q <= '0;
      end else begin
         stage_q      <= stage_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign valid_o        = stage_q.valid;
   assign pc_o           = stage_q.pc;
   assign data1_o        = stage_q.data1;
   assign data2_o        = stage_q.data2;
   assign imm_o          = stage_q.imm;
   assign rs1_o          = stage_q.rs1;
   assign rs2_o          = stage_q.rs2;
   assign rd_o           = stage_q.rd;
   assign ctrl_o         = stage_q.ctrl;
   assign bubble_count_o = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_pipe
// Purpose : Self-checking bench for id_ex_pipe: operand-select vectors,
//           hand-written hazard/stall/flush/reset sequences and randomized
//           traffic against a behavioural model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_id_ex_pipe;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        valid_i;
   logic [31:0] pc_i, data1_i, data2_i, imm_i, wb_data_i;
   logic [4:0]  rs1_i, rs2_i, rd_i, wb_addr_i;
   logic        use_rs1_i, use_rs2_i, stall_i, flush_i, wb_write_i;
   logic [15:0] ctrl_i;
   logic        valid_o, stall_req_o;
   logic [31:0] pc_o, data1_o, data2_o, imm_o;
   logic [4:0]  rs1_o, rs2_o, rd_o;
   logic [15:0] ctrl_o, bubble_count_o;

   id_ex_pipe dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .pc_i(pc_i),
      .data1_i(data1_i), .data2_i(data2_i), .imm_i(imm_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
      .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i), .ctrl_i(ctrl_i),
      .stall_i(stall_i), .flush_i(flush_i), .wb_write_i(wb_write_i),
      .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .valid_o(valid_o), .pc_o(pc_o), .data1_o(data1_o), .data2_o(data2_o),
      .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
      .ctrl_o(ctrl_o), .stall_req_o(stall_req_o), .bubble_count_o(bubble_count_o)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [15:0] LD_CTRL  = 16'h0005;  // MEM_READ | REG_WRITE
   localparam logic [15:0] ADD_CTRL = 16'h0004;  // REG_WRITE

   int errors = 0;
   int checks = 0;

   // Behavioural model of the visible stage contents.
   typedef struct packed {
      logic        valid;
      logic [31:0] pc, d1, d2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [15:0] ctrl;
   } mstate_t;
   mstate_t     m;
   logic [15:0] m_cnt;

   typedef struct {
      logic [4:0]  rs1; logic [31:0] d1;
      logic [4:0]  rs2; logic [31:0] d2;
      logic        wbw; logic [4:0] wba; logic [31:0] wbd;
      logic [31:0] e1;  logic [31:0] e2;
   } vec_t;
   vec_t vt[8];

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [159:0] dut_out();
      return {valid_o, pc_o, data1_o, data2_o, imm_o, rs1_o, rs2_o, rd_o, ctrl_o};
   endfunction

   function automatic logic [31:0] pick(input logic [4:0] rs, input logic [31:0] rd_data);
      if (rs == 5'd0) return 32'd0;
      if (wb_write_i && wb_addr_i == rs) return wb_data_i;
      return rd_data;
   endfunction

   function automatic logic model_hz();
      return m.valid && m.ctrl[0] && (m.rd != 5'd0) && valid_i &&
             ((use_rs1_i && rs1_i == m.rd) || (use_rs2_i && rs2_i == m.rd));
   endfunction

   task automatic model_edge();
      logic h;
      h = model_hz();
      if (flush_i) begin
         m = '0;
      end else if (stall_i) begin
         if (wb_write_i && wb_addr_i == m.rs1 && m.rs1 != 5'd0) m.d1 = wb_data_i;
         if (wb_write_i && wb_addr_i == m.rs2 && m.rs2 != 5'd0) m.d2 = wb_data_i;
      end else if (h) begin
         m = '0;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
         m.valid = valid_i; m.pc = pc_i; m.imm = imm_i;
         m.d1 = pick(rs1_i, data1_i); m.d2 = pick(rs2_i, data2_i);
         m.rs1 = rs1_i; m.rs2 = rs2_i; m.rd = rd_i;
         m.ctrl = valid_i ? ctrl_i : 16'h0;
      end
   endtask

   // One clock: check STALL_REQ, clock, check all outputs against the model.
   task automatic cycle(input string tag);
      #1;
      chk({tag, " stall_req"}, 160'(stall_req_o), 160'(model_hz() && !stall_i && !flush_i));
      @(posedge clk_i);
      model_edge();
      @(negedge clk_i);
      chk({tag, " outputs"}, dut_out(), m);
      chk({tag, " count"}, 160'(bubble_count_o), 160'(m_cnt));
   endtask

   task automatic set_instr(input logic v, input logic [31:0] pc, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] imm, input logic [4:0] r1,
                            input logic [4:0] r2, input logic [4:0] rd, input logic u1,
                            input logic u2, input logic [15:0] ctrl);
      valid_i = v; pc_i = pc; data1_i = a; data2_i = b; imm_i = imm;
      rs1_i = r1; rs2_i = r2; rd_i = rd; use_rs1_i = u1; use_rs2_i = u2; ctrl_i = ctrl;
   endtask

   initial begin
      mstate_t hold;
      rst_ni = 1'b0;
      set_instr(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 16'h0);
      stall_i = 1'b0; flush_i = 1'b0; wb_write_i = 1'b0; wb_addr_i = 0; wb_data_i = 0;
      m = '0; m_cnt = 16'h0;

      vt[0] = '{5'd5,  32'd0,          5'd6,  32'h66, 1'b1, 5'd5,  32'd95,        32'd95,        32'h66};
      vt[1] = '{5'd0,  32'h1234,       5'd7,  32'h77, 1'b1, 5'd0,  32'd7,         32'd0,         32'h77};
      vt[2] = '{5'd9,  32'hAA,         5'd9,  32'hBB, 1'b1, 5'd9,  32'hCC,        32'hCC,        32'hCC};
      vt[3] = '{5'd9,  32'hAA,         5'd9,  32'hBB, 1'b0, 5'd9,  32'hCC,        32'hAA,        32'hBB};
      vt[4] = '{5'd0,  32'hFFFF_FFFF,  5'd0,  32'h1,  1'b0, 5'd0,  32'h0,         32'd0,         32'd0};
      vt[5] = '{5'd31, 32'h1,          5'd30, 32'h2,  1'b1, 5'd30, 32'hDEADBEEF,  32'h1,         32'hDEADBEEF};
      vt[6] = '{5'd12, 32'h3,          5'd13, 32'h4,  1'b1, 5'd14, 32'h5,         32'h3,         32'h4};
      vt[7] = '{5'd1,  32'h10,         5'd0,  32'h20, 1'b1, 5'd1,  32'h8000_0000, 32'h8000_0000, 32'd0};

      // Reset state
      @(negedge clk_i); @(negedge clk_i);
      chk("reset outputs", dut_out(), 160'd0);
      chk("reset count", 160'(bubble_count_o), 160'd0);
      rst_ni = 1'b1;

      // Operand select vectors
      for (int i = 0; i < 8; i++) begin
         set_instr(1'b1, 32'(i * 4), vt[i].d1, vt[i].d2, 32'(i), vt[i].rs1, vt[i].rs2,
                   5'(i + 1), 1'b1, 1'b1, ADD_CTRL);
         wb_write_i = vt[i].wbw; wb_addr_i = vt[i].wba; wb_data_i = vt[i].wbd;
         cycle("vec");
         chk($sformatf("vec%0d data1", i), 160'(data1_o), 160'(vt[i].e1));
         chk($sformatf("vec%0d data2", i), 160'(data2_o), 160'(vt[i].e2));
         chk($sformatf("vec%0d valid", i), 160'(valid_o), 160'd1);
      end
      wb_write_i = 1'b0;

      // Invalid capture forces CTRL to NOP
      set_instr(1'b0, 32'h50, 1, 2, 3, 1, 2, 7, 1'b1, 1'b1, 16'hFFFF);
      cycle("invalid");
      chk("invalid ctrl", 160'({valid_o, ctrl_o}), 160'd0);

      // Load-use: lw x3 then add using rs2=x3
      set_instr(1'b1, 32'h40, 0, 0, 0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, LD_CTRL);
      cycle("lu load");
      chk("lu load rd", 160'(rd_o), 160'd3);
      set_instr(1'b1, 32'h44, 32'h20, 32'h30, 0, 5'd2, 5'd3, 5'd5, 1'b1, 1'b1, ADD_CTRL);
      #1 chk("lu stall_req", 160'(stall_req_o), 160'd1);
      cycle("lu bubble");
      chk("lu bubble valid", 160'(valid_o), 160'd0);
      chk("lu bubble count", 160'(bubble_count_o), 160'd1);
      #1 chk("lu stall_req drop", 160'(stall_req_o), 160'd0);
      cycle("lu add");
      chk("lu add captured", 160'({valid_o, pc_o, data2_o, rd_o}), 160'({1'b1, 32'h44, 32'h30, 5'd5}));

      // Stall hold with refresh of DATA2 from writeback in the 2nd held cycle
      set_instr(1'b1, 32'h100, 32'h11, 32'h22, 32'h44, 5'd2, 5'd4, 5'd6, 1'b1, 1'b1, ADD_CTRL);
      cycle("hold cap");
      hold = '{1'b1, 32'h100, 32'h11, 32'h22, 32'h44, 5'd2, 5'd4, 5'd6, ADD_CTRL};
      stall_i = 1'b1;
      set_instr(1'b1, 32'h200, 32'h99, 32'h98, 32'h97, 5'd4, 5'd2, 5'd7, 1'b1, 1'b1, ADD_CTRL);
      wb_write_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'd77;
      cycle("hold1");
      chk("hold1 fields", dut_out(), hold);
      wb_addr_i = 5'd4; wb_data_i = 32'd15;
      cycle("hold2");
      hold.d2 = 32'd15;
      chk("hold2 refresh", dut_out(), hold);
      wb_write_i = 1'b0;
      cycle("hold3");
      chk("hold3 fields", dut_out(), hold);
      stall_i = 1'b0;

      // FLUSH together with hz
      set_instr(1'b1, 32'h60, 0, 0, 0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, LD_CTRL);
      cycle("fl load");
      set_instr(1'b1, 32'h64, 1, 2, 0, 5'd3, 5'd2, 5'd5, 1'b1, 1'b1, ADD_CTRL);
      flush_i = 1'b1;
      #1 chk("fl stall_req", 160'(stall_req_o), 160'd0);
      cycle("fl hz");
      chk("fl bubble", 160'({valid_o, ctrl_o, rd_o}), 160'd0);
      chk("fl count", 160'(bubble_count_o), 160'd1);
      flush_i = 1'b0;

      // STALL together with hz
      set_instr(1'b1, 32'h70, 0, 0, 0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, LD_CTRL);
      cycle("st load");
      set_instr(1'b1, 32'h74, 1, 2, 0, 5'd3, 5'd2, 5'd5, 1'b1, 1'b1, ADD_CTRL);
      stall_i = 1'b1;
      #1 chk("st stall_req", 160'(stall_req_o), 160'd0);
      cycle("st hz");
      chk("st hold", 160'({valid_o, pc_o, rd_o, ctrl_o}), 160'({1'b1, 32'h70, 5'd3, LD_CTRL}));
      chk("st count", 160'(bubble_count_o), 160'd1);
      stall_i = 1'b0;

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         valid_i   = ($urandom_range(0, 99) < 85);
         pc_i      = $urandom; data1_i = $urandom; data2_i = $urandom; imm_i = $urandom;
         rs1_i     = 5'($urandom_range(0, 3));
         rs2_i     = 5'($urandom_range(0, 3));
         rd_i      = 5'($urandom_range(0, 3));
         use_rs1_i = 1'($urandom_range(0, 1));
         use_rs2_i = 1'($urandom_range(0, 1));
         ctrl_i    = 16'($urandom);
         ctrl_i[0] = 1'($urandom_range(0, 1));
         stall_i   = ($urandom_range(0, 99) < 15);
         flush_i   = ($urandom_range(0, 99) < 8);
         wb_write_i = 1'($urandom_range(0, 1));
         wb_addr_i  = 5'($urandom_range(0, 3));
         wb_data_i  = $urandom;
         cycle("rand");
      end
      stall_i = 1'b0; flush_i = 1'b0; wb_write_i = 1'b0;

      // Saturation: preload the counter near the top, then keep bubbling
      force dut.bubble_cnt_q = 16'hFFFD;
      #1 release dut.bubble_cnt_q;
      m_cnt = 16'hFFFD;
      set_instr(1'b1, 32'h80, 0, 0, 0, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, LD_CTRL);
      for (int k = 0; k < 8; k++) cycle("sat");
      chk("sat count", 160'(bubble_count_o), 160'hFFFF);

      // Reset asserted mid-cycle while holding a valid instruction
      set_instr(1'b1, 32'h90, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, ADD_CTRL);
      cycle("pre rst");
      #2 rst_ni = 1'b0;
      #1;
      chk("async rst outputs", dut_out(), 160'd0);
      chk("async rst count", 160'(bubble_count_o), 160'd0);
      chk("async rst stall_req", 160'(stall_req_o), 160'd0);
      m = '0; m_cnt = 16'h0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      set_instr(1'b1, 32'hA0, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, ADD_CTRL);
      cycle("post rst");
      chk("post rst capture", 160'({valid_o, pc_o, rd_o}), 160'({1'b1, 32'hA0, 5'd9}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
